// File: rtl/n64_vinfo_ctrl.sv
// n64_vinfo_ctrl
//   Supervisory controller behind the N64 video-info extractor.
//   - Qualifies the raw vmode / 480i decisions over FRAME_STABLE
//     consecutive frames before committing them to the outputs.
//   - Tracks input presence with two watchdogs:
//       * nDSYNC stuck high for WD_CYCLES cycles
//       * MAX_LINES nHSYNC rising edges without a frame tick
//   - Applies configuration updates on frame boundaries while a signal
//     is present, or immediately while there is no signal.
//
// Ports
//   VCLK        in   video clock
//   RST         in   asynchronous active-high reset
//   nDSYNC      in   data-sync strobe, low on the sync/phase-0 cycle
//   Sync_cur    in   current sync nibble (bit3 nVSYNC, bit1 nHSYNC)
//   vmode_i     in   raw vmode from extractor (1 = PAL)
//   n64_480i_i  in   raw interlace flag from extractor
//   cfg_req     in   configuration update request (level)
//   cfg_i       in   requested configuration word
//   vmode_o     out  committed vmode
//   n64_480i_o  out  committed interlace flag
//   locked_o    out  high while in LOCKED
//   mode_chg_o  out  one-cycle pulse when a changed value is committed in LOCKED
//   cfg_o       out  active configuration word
//   cfg_ack_o   out  one-cycle pulse when cfg_i has been applied
module n64_vinfo_ctrl #(
   parameter int                FRAME_STABLE = 3,
   parameter int                WD_CYCLES    = 1023,
   parameter int                MAX_LINES    = 1023,
   parameter int                CFG_W        = 8,
   parameter logic [CFG_W-1:0]  CFG_RST      = '0
) (
   input  logic             VCLK,
   input  logic             RST,
   input  logic             nDSYNC,
   input  logic [3:0]       Sync_cur,
   input  logic             vmode_i,
   input  logic             n64_480i_i,
   input  logic             cfg_req,
   input  logic [CFG_W-1:0] cfg_i,
   output logic             vmode_o,
   output logic             n64_480i_o,
   output logic             locked_o,
   output logic             mode_chg_o,
   output logic [CFG_W-1:0] cfg_o,
   output logic             cfg_ack_o
);

   localparam logic [3:0] STAB_MAX = 4'(FRAME_STABLE);
   localparam logic [9:0] WD_MAX   = 10'(WD_CYCLES);
   localparam logic [9:0] LINE_MAX = 10'(MAX_LINES);

   typedef enum logic [1:0] {
      NO_SIG  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [3:0]         sync_pre_reg;
   logic               frame_tick_reg;
   logic [9:0]         dsync_wd_reg;
   logic [9:0]         line_cnt_reg;
   logic [1:0]         cand_reg, cand_next;
   logic [3:0]         stab_cnt_reg, stab_next;
   logic               vmode_reg, i480_reg, mode_chg_reg;
   logic [CFG_W-1:0]   cfg_reg;
   logic               cfg_ack_reg;
   logic               armed_reg;

   logic               frame_ev, line_ev;
   logic               wd_expired, line_expired;
   logic [1:0]         sample, committed;
   logic               commit, chg_next;
   logic               cfg_apply;

   // Only the nVSYNC/nHSYNC bits take part in edge detection.
   logic               unused_sync;
   assign unused_sync = ^{Sync_cur[2], Sync_cur[0], sync_pre_reg[2], sync_pre_reg[0]};

   // Edges are only meaningful on strobe cycles, where Sync_pre holds the
   // nibble of the previous strobe cycle.
   assign frame_ev = ~nDSYNC & ~sync_pre_reg[3] & Sync_cur[3];
   assign line_ev  = ~nDSYNC & ~sync_pre_reg[1] & Sync_cur[1];

   // The extractor updates its outputs on the same edge that raises the tick,
   // so the sample taken during the tick cycle is the fresh one.
   assign sample    = {vmode_i, n64_480i_i};
   assign committed = {vmode_reg, i480_reg};

   assign wd_expired   = (dsync_wd_reg == WD_MAX);
   // A tick clears line_cnt on this edge, so a saturated count does not
   // count as loss while a frame is actually arriving.
   assign line_expired = (line_cnt_reg == LINE_MAX) & ~frame_tick_reg;

   // Candidate tracking. Entering from NO_SIG always restarts the count so a
   // stale candidate from before signal loss cannot shorten qualification.
   always_comb begin
      cand_next = cand_reg;
      stab_next = stab_cnt_reg;
      if (frame_tick_reg) begin
         cand_next = sample;
         if ((state_reg == NO_SIG) || (sample != cand_reg)) begin
            stab_next = 4'd1;
         end else if (stab_cnt_reg != STAB_MAX) begin
            stab_next = stab_cnt_reg + 4'd1;
         end
      end
   end

   // Next state and commit decision; commits land on the outputs one edge
   // after the tick, i.e. two cycles after the frame event.
   always_comb begin
      state_next = state_reg;
      commit     = 1'b0;
      chg_next   = 1'b0;
      if (wd_expired || line_expired) begin
         state_next = NO_SIG;
      end else begin
         case (state_reg)
            NO_SIG: begin
               if (frame_tick_reg) state_next = ACQUIRE;
            end
            ACQUIRE: begin
               if (frame_tick_reg && (stab_next == STAB_MAX)) begin
                  state_next = LOCKED;
                  commit     = 1'b1;
               end
            end
            LOCKED: begin
               if (frame_tick_reg && (stab_next == STAB_MAX) && (cand_next != committed)) begin
                  commit   = 1'b1;
                  chg_next = 1'b1;
               end
            end
            default: state_next = NO_SIG;
         endcase
      end
   end

   // Apply decision uses the current state, so a watchdog expiring in the
   // same cycle does not cancel an apply already due.
   assign cfg_apply = cfg_req & armed_reg & ((state_reg == NO_SIG) | frame_tick_reg);

   always_ff @(posedge VCLK or posedge RST) begin
      if (RST) begin
         state_reg <= NO_SIG;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge VCLK or posedge RST) begin
      if (RST) begin
         sync_pre_reg   <= 4'hF;
         frame_tick_reg <= 1'b0;
         dsync_wd_reg   <= '0;
         line_cnt_reg   <= '0;
         cand_reg       <= '0;
         stab_cnt_reg   <= '0;
      end else begin
         if (!nDSYNC) sync_pre_reg <= Sync_cur;
         frame_tick_reg <= frame_ev;

         if (!nDSYNC) begin
            dsync_wd_reg <= '0;
         end else if (dsync_wd_reg != WD_MAX) begin
            dsync_wd_reg <= dsync_wd_reg + 10'd1;
         end

         if (frame_tick_reg) begin
            line_cnt_reg <= '0;
         end else if (line_ev && (line_cnt_reg != LINE_MAX)) begin
            line_cnt_reg <= line_cnt_reg + 10'd1;
         end

         cand_reg     <= cand_next;
         stab_cnt_reg <= stab_next;
      end
   end

   always_ff @(posedge VCLK or posedge RST) begin
      if (RST) begin
         vmode_reg    <= 1'b0;
         i480_reg     <= 1'b1;
         mode_chg_reg <= 1'b0;
      end else begin
         if (commit) begin
            vmode_reg <= cand_next[1];
            i480_reg  <= cand_next[0];
         end
         mode_chg_reg <= chg_next;
      end
   end

   // armed_reg starts set so the first request after reset is honoured;
   // it drops on apply and only returns once cfg_req has been seen low.
   always_ff @(posedge VCLK or posedge RST) begin
      if (RST) begin
         cfg_reg     <= CFG_RST;
         cfg_ack_reg <= 1'b0;
         armed_reg   <= 1'b1;
      end else begin
         if (cfg_apply) cfg_reg <= cfg_i;
         cfg_ack_reg <= cfg_apply;
         if (cfg_apply) begin
            armed_reg <= 1'b0;
         end else if (!cfg_req) begin
            armed_reg <= 1'b1;
         end
      end
   end

   assign vmode_o    = vmode_reg;
   assign n64_480i_o = i480_reg;
   assign locked_o   = (state_reg == LOCKED);
   assign mode_chg_o = mode_chg_reg;
   assign cfg_o      = cfg_reg;
   assign cfg_ack_o  = cfg_ack_reg;

endmodule

// File: tb/tb_n64_vinfo_ctrl.sv
// tb_n64_vinfo_ctrl
//   Directed bench for n64_vinfo_ctrl. Inputs change 1 ns after the rising
//   edge and outputs are sampled there as well, away from the active edge.
module tb_n64_vinfo_ctrl;

   logic       VCLK;
   logic       RST;
   logic       nDSYNC;
   logic [3:0] Sync_cur;
   logic       vmode_i;
   logic       n64_480i_i;
   logic       cfg_req;
   logic [7:0] cfg_i;
   logic       vmode_o;
   logic       n64_480i_o;
   logic       locked_o;
   logic       mode_chg_o;
   logic [7:0] cfg_o;
   logic       cfg_ack_o;

   int vectors    = 0;
   int miscompares = 0;
   int ack_cnt    = 0;
   int chg_cnt    = 0;

   n64_vinfo_ctrl dut (
      .VCLK       (VCLK),
      .RST        (RST),
      .nDSYNC     (nDSYNC),
      .Sync_cur   (Sync_cur),
      .vmode_i    (vmode_i),
      .n64_480i_i (n64_480i_i),
      .cfg_req    (cfg_req),
      .cfg_i      (cfg_i),
      .vmode_o    (vmode_o),
      .n64_480i_o (n64_480i_o),
      .locked_o   (locked_o),
      .mode_chg_o (mode_chg_o),
      .cfg_o      (cfg_o),
      .cfg_ack_o  (cfg_ack_o)
   );

   initial VCLK = 1'b0;
   always #5 VCLK = ~VCLK;

   // Pulse counters, so that a stray pulse between check points is caught.
   always @(negedge VCLK) begin
      if (cfg_ack_o === 1'b1)  ack_cnt++;
      if (mode_chg_o === 1'b1) chg_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
         else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
      $display("check %-14s observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock cycle with the given strobe/sync inputs; returns 1 ns after
   // the edge that sampled them.
   task automatic drive(input logic nd, input logic [3:0] s);
      nDSYNC   = nd;
      Sync_cur = s;
      @(posedge VCLK);
      #1;
   endtask

   // One frame: nVSYNC low on a strobe, then high on the next strobe (event
   // cycle t), then one more strobe cycle. Returns at t+2.
   task automatic frame(input logic vm, input logic il);
      vmode_i    = vm;
      n64_480i_i = il;
      drive(1'b0, 4'h0);
      drive(1'b0, 4'hA);
      drive(1'b0, 4'hA);
   endtask

   initial begin
      RST = 1'b1; nDSYNC = 1'b1; Sync_cur = 4'hF;
      vmode_i = 1'b0; n64_480i_i = 1'b0; cfg_req = 1'b0; cfg_i = 8'h00;
      @(posedge VCLK); @(posedge VCLK); #1;

      // Reset state
      check("rst_vmode", vmode_o, 1'b0);
      check("rst_480i", n64_480i_o, 1'b1);
      check("rst_locked", locked_o, 1'b0);
      check("rst_chg", mode_chg_o, 1'b0);
      check("rst_cfg", cfg_o, 8'h00);
      check("rst_ack", cfg_ack_o, 1'b0);
      RST = 1'b0;

      // Acquire NTSC progressive over three frames
      frame(1'b0, 1'b0);
      frame(1'b0, 1'b0);
      check("acq_2fr_lock", locked_o, 1'b0);
      frame(1'b0, 1'b0);
      check("acq_3fr_lock", locked_o, 1'b1);
      check("acq_vmode", vmode_o, 1'b0);
      check("acq_480i", n64_480i_o, 1'b0);
      check("acq_chg", mode_chg_o, 1'b0);

      // Short mismatch is filtered, three stable frames commit with a pulse
      frame(1'b1, 1'b0);
      frame(1'b1, 1'b0);
      frame(1'b0, 1'b0);
      check("glitch_vmode", vmode_o, 1'b0);
      check("glitch_chgcnt", chg_cnt, 0);
      frame(1'b1, 1'b0);
      frame(1'b1, 1'b0);
      check("pal_2fr_vmode", vmode_o, 1'b0);
      frame(1'b1, 1'b0);
      check("pal_3fr_vmode", vmode_o, 1'b1);
      check("pal_chg_pulse", mode_chg_o, 1'b1);
      drive(1'b0, 4'hA);
      check("pal_chg_end", mode_chg_o, 1'b0);
      check("pal_chgcnt", chg_cnt, 1);

      // Config while LOCKED waits for the frame boundary
      cfg_i = 8'hA5; cfg_req = 1'b1;
      repeat (3) drive(1'b0, 4'hA);
      check("cfg_midframe", cfg_o, 8'h00);
      check("cfg_noack", ack_cnt, 0);
      frame(1'b1, 1'b0);
      check("cfg_applied", cfg_o, 8'hA5);
      check("cfg_ack", cfg_ack_o, 1'b1);
      drive(1'b0, 4'hA);
      check("cfg_ack_end", cfg_ack_o, 1'b0);
      repeat (3) frame(1'b1, 1'b0);
      drive(1'b0, 4'hA);
      check("cfg_one_ack", ack_cnt, 1);
      check("cfg_held", cfg_o, 8'hA5);
      cfg_req = 1'b0;
      drive(1'b0, 4'hA);

      // nDSYNC watchdog: still locked at 1023 high cycles, lost one later
      repeat (1023) drive(1'b1, 4'hA);
      check("wd_edge_lock", locked_o, 1'b1);
      drive(1'b1, 4'hA);
      check("wd_lost_lock", locked_o, 1'b0);
      check("wd_hold_vmode", vmode_o, 1'b1);
      check("wd_hold_480i", n64_480i_o, 1'b0);

      // First frame after loss enters ACQUIRE; commit from ACQUIRE gives no pulse
      frame(1'b0, 1'b1);
      check("reacq_1_lock", locked_o, 1'b0);
      frame(1'b0, 1'b1);
      frame(1'b0, 1'b1);
      check("reacq_3_lock", locked_o, 1'b1);
      check("reacq_vmode", vmode_o, 1'b0);
      check("reacq_480i", n64_480i_o, 1'b1);
      drive(1'b0, 4'hA);
      check("reacq_chgcnt", chg_cnt, 1);

      // Change committed value while LOCKED
      repeat (3) frame(1'b1, 1'b0);
      check("pal2_vmode", vmode_o, 1'b1);
      check("pal2_480i", n64_480i_o, 1'b0);
      drive(1'b0, 4'hA);
      check("pal2_chgcnt", chg_cnt, 2);

      // Line watchdog: 1023 nHSYNC edges with no frame
      repeat (1023) begin
         drive(1'b0, 4'h8);
         drive(1'b0, 4'hA);
      end
      check("line_edge_lock", locked_o, 1'b1);
      drive(1'b0, 4'h8);
      check("line_lost_lock", locked_o, 1'b0);
      check("line_hold_vm", vmode_o, 1'b1);

      // Config in NO_SIG applies on the next cycle
      cfg_i = 8'h3C; cfg_req = 1'b1;
      drive(1'b0, 4'h8);
      check("nosig_cfg", cfg_o, 8'h3C);
      check("nosig_ack", cfg_ack_o, 1'b1);
      cfg_req = 1'b0;
      drive(1'b0, 4'h8);
      check("nosig_ack_end", cfg_ack_o, 1'b0);

      // Asynchronous reset in the middle of ACQUIRE
      frame(1'b0, 1'b0);
      check("acq2_lock", locked_o, 1'b0);
      check("pre_rst_cfg", cfg_o, 8'h3C);
      #2;
      RST = 1'b1;
      #1;
      check("arst_vmode", vmode_o, 1'b0);
      check("arst_480i", n64_480i_o, 1'b1);
      check("arst_cfg", cfg_o, 8'h00);
      check("arst_locked", locked_o, 1'b0);
      check("arst_ack", cfg_ack_o, 1'b0);
      check("arst_chg", mode_chg_o, 1'b0);
      @(posedge VCLK); #1;
      RST = 1'b0;

      // Fresh qualification after reset
      frame(1'b0, 1'b0);
      frame(1'b0, 1'b0);
      check("post_2fr_lock", locked_o, 1'b0);
      frame(1'b0, 1'b0);
      check("post_3fr_lock", locked_o, 1'b1);
      check("post_480i", n64_480i_o, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
